// File: rtl/alien_grid.sv
// alien_grid: ROWS x COLS alien formation sitting downstream of the laser block.
// On each enable tick it resolves a laser hit against the live-alien map
// (using the pre-move grid position), marches the formation, and tracks
// win/loss. It also produces the per-pixel alien colour for the display mux.
//
// Ports:
//   clk, reset    system clock; synchronous active-high reset
//   enable        one-cycle frame tick; all state changes happen only on it
//   xLaser/yLaser laser centre (639,479 when the laser is dead)
//   hPos/vPos     current pixel coordinate
//   killingAlien  registered hit pulse back to the laser block
//   colorAlien    combinational pixel colour (ALIEN / BACKGROUND)
//   xGrid/yGrid   registered formation top-left corner
//   aliensLeft    registered live-alien count
//   gameWon/Lost  registered sticky end-of-game flags
//
// Optional feature macro: ALIEN_SPEEDUP_EN (halves / quarters the move period
// as the formation thins out).
module alien_grid #(
  parameter int COLS         = 8,
  parameter int ROWS         = 4,
  parameter int PITCH_X      = 64,
  parameter int PITCH_Y      = 32,
  parameter int ALIEN_W      = 40,
  parameter int ALIEN_H      = 20,
  parameter int X_START      = 64,
  parameter int Y_START      = 40,
  parameter int STEP_X       = 4,
  parameter int STEP_Y       = 16,
  parameter int MOVE_PERIOD  = 8,
  parameter int SCREEN_WIDTH = 640,
  parameter int INVASION_Y   = 400,
  parameter int ALIEN        = 2,
  parameter int BACKGROUND   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] xLaser,
  input  logic [9:0] yLaser,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic       killingAlien,
  output logic [2:0] colorAlien,
  output logic [9:0] xGrid,
  output logic [9:0] yGrid,
  output logic [5:0] aliensLeft,
  output logic       gameWon,
  output logic       gameLost
);
  localparam int N   = ROWS * COLS;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int PXS = $clog2(PITCH_X);
  localparam int PYS = $clog2(PITCH_Y);
  localparam int CW  = $clog2(MOVE_PERIOD);

  localparam logic [10:0] SPAN_X   = 11'(COLS * PITCH_X);
  localparam logic [10:0] SPAN_Y   = 11'(ROWS * PITCH_Y);
  localparam logic [9:0]  MASK_X   = 10'(PITCH_X - 1);
  localparam logic [9:0]  MASK_Y   = 10'(PITCH_Y - 1);
  localparam logic [9:0]  AW       = 10'(ALIEN_W);
  localparam logic [9:0]  AH       = 10'(ALIEN_H);
  localparam logic [9:0]  COLS10   = 10'(COLS);
  // Full formation extent (dead columns included) for the right-edge test.
  localparam logic [10:0] RIGHT_OFF = 11'(STEP_X + (COLS - 1) * PITCH_X + ALIEN_W);
  localparam logic [10:0] BOT_OFF   = 11'((ROWS - 1) * PITCH_Y + ALIEN_H);

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
  } loc_t;

  // Box test of a point against the formation; division by the power-of-two
  // pitch is done with shifts and masks.
  function automatic loc_t locate(input logic [9:0] px, input logic [9:0] py,
                                  input logic [9:0] gx, input logic [9:0] gy);
    logic [9:0] rx, ry;
    loc_t r;
    rx = px - gx;
    ry = py - gy;
    r.hit = (px >= gx) && (py >= gy) &&
            ({1'b0, rx} < SPAN_X) && ({1'b0, ry} < SPAN_Y) &&
            ((rx & MASK_X) < AW) && ((ry & MASK_Y) < AH);
    r.idx = IW'((ry >> PYS) * COLS10 + (rx >> PXS));
    return r;
  endfunction

  logic [N-1:0]  alive_q, alive_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    xgrid_q, xgrid_d, ygrid_q, ygrid_d;
  logic [5:0]    left_q, left_d;
  logic          kill_q, kill_d, won_q, won_d, lost_q, lost_d;

  loc_t          las, pix;
  logic          hit, rev;
  logic [CW-1:0] per_m1;

  always_comb begin
`ifdef ALIEN_SPEEDUP_EN
    if (left_q <= 6'(N / 4))      per_m1 = CW'(MOVE_PERIOD / 4 - 1);
    else if (left_q <= 6'(N / 2)) per_m1 = CW'(MOVE_PERIOD / 2 - 1);
    else                          per_m1 = CW'(MOVE_PERIOD - 1);
`else
    per_m1 = CW'(MOVE_PERIOD - 1);
`endif
  end

  always_comb begin
    alive_d = alive_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    xgrid_d = xgrid_q;
    ygrid_d = ygrid_q;
    left_d  = left_q;
    kill_d  = kill_q;
    won_d   = won_q;
    lost_d  = lost_q;
    rev     = 1'b0;
    las     = locate(xLaser, yLaser, xgrid_q, ygrid_q);
    hit     = las.hit && alive_q[las.idx];
    if (enable) begin
      kill_d = 1'b0;
      if (!won_q && !lost_q) begin
        // A pending kill pulse blocks evaluation so one shot kills once.
        if (!kill_q && hit) begin
          alive_d[las.idx] = 1'b0;
          left_d = left_q - 6'd1;
          kill_d = 1'b1;
          if (left_q == 6'd1) won_d = 1'b1;
        end
        // ">=" lets a counter beyond a shortened period wrap at once.
        if (cnt_q >= per_m1) begin
          cnt_d = '0;
          if (dir_q) begin
            if ({1'b0, xgrid_q} + RIGHT_OFF <= 11'(SCREEN_WIDTH))
              xgrid_d = xgrid_q + 10'(STEP_X);
            else
              rev = 1'b1;
          end else begin
            if (xgrid_q >= 10'(STEP_X)) xgrid_d = xgrid_q - 10'(STEP_X);
            else                        rev = 1'b1;
          end
          if (rev) begin
            ygrid_d = ygrid_q + 10'(STEP_Y);
            dir_d   = ~dir_q;
            if ({1'b0, ygrid_d} + BOT_OFF >= 11'(INVASION_Y)) lost_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alive_q <= '1;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      xgrid_q <= 10'(X_START);
      ygrid_q <= 10'(Y_START);
      left_q  <= 6'(N);
      kill_q  <= 1'b0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      alive_q <= alive_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      xgrid_q <= xgrid_d;
      ygrid_q <= ygrid_d;
      left_q  <= left_d;
      kill_q  <= kill_d;
      won_q   <= won_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    pix        = locate(hPos, vPos, xgrid_q, ygrid_q);
    colorAlien = (pix.hit && alive_q[pix.idx]) ? 3'(ALIEN) : 3'(BACKGROUND);
  end

  assign killingAlien = kill_q;
  assign xGrid        = xgrid_q;
  assign yGrid        = ygrid_q;
  assign aliensLeft   = left_q;
  assign gameWon      = won_q;
  assign gameLost     = lost_q;
endmodule

// File: tb/tb_alien_grid.sv
// Self-checking bench for alien_grid (default parameters, speed-up disabled).
module tb_alien_grid;
  logic       clk = 0, reset = 0, enable = 0;
  logic [9:0] xLaser = 10'd639, yLaser = 10'd479, hPos = 0, vPos = 0;
  logic       killingAlien, gameWon, gameLost;
  logic [2:0] colorAlien;
  logic [9:0] xGrid, yGrid;
  logic [5:0] aliensLeft;

  alien_grid dut (
    .clk(clk), .reset(reset), .enable(enable),
    .xLaser(xLaser), .yLaser(yLaser), .hPos(hPos), .vPos(vPos),
    .killingAlien(killingAlien), .colorAlien(colorAlien),
    .xGrid(xGrid), .yGrid(yGrid), .aliensLeft(aliensLeft),
    .gameWon(gameWon), .gameLost(gameLost)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int tcnt = 0;

  typedef struct {
    string      nm;
    logic       kill;
    logic [5:0] left;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string      nm;
    bit         rst;
    int         xl, yl;
    logic       kill;
    logic [5:0] left;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    tcnt = 0;
  endtask

  // One enable tick; outputs are stable at the returning negedge.
  task automatic tick();
    @(negedge clk) enable = 1;
    @(negedge clk) enable = 0;
    tcnt++;
  endtask

  task automatic sb_push(input string nm, input logic k, input logic [5:0] l);
    exp_t e;
    e.nm = nm; e.kill = k; e.left = l;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk({e.nm, "_kill"}, 32'(killingAlien), 32'(e.kill));
      chk({e.nm, "_left"}, 32'(aliensLeft), 32'(e.left));
    end
  endtask

  // Aim at the centre-ish of alien k; grid marches right 4 px every 8 ticks
  // from x=64 (valid while no reversal has happened).
  task automatic aim(input int k);
    xLaser = 10'(64 + 4 * (tcnt / 8) + (k % 8) * 64 + 20);
    yLaser = 10'(40 + (k / 8) * 32 + 10);
  endtask

  task automatic idle_laser();
    xLaser = 10'd639; yLaser = 10'd479;
  endtask

  vec_t vt[13];
  logic [9:0] xs, ys;
  int n;

  initial begin
    vt[0]  = '{"gap",        1, 110,  50, 0, 32};
    vt[1]  = '{"hit0",       0,  84,  50, 1, 31};
    vt[2]  = '{"hold_noeval",0,  84,  50, 0, 31};
    vt[3]  = '{"hold_dead",  0,  84,  50, 0, 31};
    vt[4]  = '{"hit1",       0, 148,  50, 1, 30};
    vt[5]  = '{"idle",       0, 639, 479, 0, 30};
    vt[6]  = '{"hit31",      0, 532, 141, 1, 29};
    vt[7]  = '{"left_of",    1,  63,  50, 0, 32};
    vt[8]  = '{"xw_edge",    0, 104,  50, 0, 32};
    vt[9]  = '{"box_corner", 0, 103,  59, 1, 31};
    vt[10] = '{"idle2",      0, 639, 479, 0, 31};
    vt[11] = '{"yh_edge",    0, 167,  60, 0, 31};
    vt[12] = '{"below",      0,  84, 168, 0, 31};

    do_reset();
    chk("rst_left", 32'(aliensLeft), 32'd32);
    chk("rst_x", 32'(xGrid), 32'd64);
    chk("rst_y", 32'(yGrid), 32'd40);
    chk("rst_kill", 32'(killingAlien), 32'd0);
    chk("rst_won", 32'(gameWon), 32'd0);
    chk("rst_lost", 32'(gameLost), 32'd0);

    // Colour probes against the full formation.
    hPos = 64;  vPos = 40;  #1 chk("col_tl", 32'(colorAlien), 32'd2);
    hPos = 104; vPos = 40;  #1 chk("col_xgap", 32'(colorAlien), 32'd0);
    hPos = 63;  vPos = 40;  #1 chk("col_left", 32'(colorAlien), 32'd0);
    hPos = 64;  vPos = 60;  #1 chk("col_ygap", 32'(colorAlien), 32'd0);
    hPos = 551; vPos = 155; #1 chk("col_br", 32'(colorAlien), 32'd2);

    // Table-driven hit vectors.
    for (int i = 0; i < 13; i++) begin
      if (vt[i].rst) do_reset();
      xLaser = 10'(vt[i].xl); yLaser = 10'(vt[i].yl);
      sb_push(vt[i].nm, vt[i].kill, vt[i].left);
      tick();
      sb_check();
    end
    // Alive bit 0 was killed above: its pixel is now background.
    hPos = 70; vPos = 45; #1 chk("col_dead", 32'(colorAlien), 32'd0);

    // March and reversal with idle laser.
    do_reset(); idle_laser();
    for (int t = 1; t <= 192; t++) begin
      tick();
      if (t == 7)   chk("mv_t7_x", 32'(xGrid), 32'd64);
      if (t == 8)   chk("mv_t8_x", 32'(xGrid), 32'd68);
      if (t == 176) chk("mv_t176_x", 32'(xGrid), 32'd152);
      if (t == 183) chk("mv_t183_y", 32'(yGrid), 32'd40);
      if (t == 184) begin
        chk("rev_y", 32'(yGrid), 32'd56);
        chk("rev_x", 32'(xGrid), 32'd152);
      end
      if (t == 192) chk("left_x", 32'(xGrid), 32'd148);
    end

    // Kill all 32 aliens.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      aim(k);
      sb_push("kill_all", 1, 6'(31 - k));
      tick(); sb_check();
      if (k == 31) chk("won_last", 32'(gameWon), 32'd1);
      idle_laser();
      sb_push("kill_all_gap", 0, 6'(31 - k));
      tick(); sb_check();
    end
    for (int t = 0; t < 100; t++) tick();
    chk("won_x_frozen", 32'(xGrid), 32'd92);
    chk("won_y_frozen", 32'(yGrid), 32'd40);
    chk("won_sticky", 32'(gameWon), 32'd1);

    // Reset mid-game right after a kill.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      aim(k); tick(); idle_laser();
      if (k < 4) tick();
    end
    chk("pre_rst_kill", 32'(killingAlien), 32'd1);
    do_reset();
    chk("mid_rst_left", 32'(aliensLeft), 32'd32);
    chk("mid_rst_x", 32'(xGrid), 32'd64);
    chk("mid_rst_y", 32'(yGrid), 32'd40);
    chk("mid_rst_kill", 32'(killingAlien), 32'd0);
    chk("mid_rst_won", 32'(gameWon), 32'd0);

    // Invasion: idle until gameLost, bounded.
    n = 0;
    while (!gameLost && n < 20000) begin tick(); n++; end
    if (!gameLost) begin
      checks++; errors++;
      $display("FAIL lost_timeout: got 0 expected 1");
    end else begin
      chk("lost_y", 32'(yGrid), 32'd296);
      chk("lost_x", 32'(xGrid), 32'd0);
      chk("lost_won", 32'(gameWon), 32'd0);
      xs = xGrid; ys = yGrid;
      xLaser = 10'd20; yLaser = 10'd306;
      sb_push("lost_nohit", 0, 32);
      tick(); sb_check();
      for (int t = 0; t < 20; t++) tick();
      chk("lost_x_frozen", 32'(xGrid), 32'd0);
      chk("lost_y_frozen", 32'(yGrid), 32'd296);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alien_grid.md
# alien_grid

Alien formation stage that sits directly downstream of the laser block. Each frame tick it consumes the laser position, resolves hits against a ROWS×COLS formation of live aliens, and returns the one-tick `killingAlien` pulse that the laser block uses to destroy its shot. It also marches the formation across the 640×480 screen, produces the per-pixel alien colour code for the display mux, and flags win and loss.

## Interface
- `COLS`, 8, aliens per row
- `ROWS`, 4, rows of aliens; `COLS*ROWS` ≤ 63
- `PITCH_X`, 64, horizontal alien pitch in px; power of two
- `PITCH_Y`, 32, vertical alien pitch in px; power of two
- `ALIEN_W`, 40, alien box width in px; < `PITCH_X`
- `ALIEN_H`, 20, alien box height in px; < `PITCH_Y`
- `X_START`, 64, `xGrid` value after reset
- `Y_START`, 40, `yGrid` value after reset
- `STEP_X`, 4, horizontal px per move
- `STEP_Y`, 16, px dropped at each edge reversal
- `MOVE_PERIOD`, 8, enable ticks per move; ≥ 4
- `SCREEN_WIDTH`, 640, screen width in px
- `INVASION_Y`, 400, formation bottom that ends the game
- `ALIEN`, 2, alien colour code
- `BACKGROUND`, 0, background colour code

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  one-cycle frame tick; all state changes occur only on this tick
- `xLaser`  in  10  laser centre x (639 when the laser is dead)
- `yLaser`  in  10  laser centre y (479 when the laser is dead)
- `hPos`  in  10  current pixel x
- `vPos`  in  10  current pixel y
- `killingAlien`  out  1  registered hit flag returned to the laser block
- `colorAlien`  out  3  combinational pixel colour
- `xGrid`  out  10  formation left edge, registered
- `yGrid`  out  10  formation top edge, registered
- `aliensLeft`  out  6  live alien count, registered
- `gameWon`  out  1  registered, sticky
- `gameLost`  out  1  registered, sticky

## Operation
**State**
- `alive[ROWS*COLS]`: bit index is row×COLS+col; row 0 is the top row.
- Direction bit: 1 means moving right.
- Move counter: 0 to MOVE_PERIOD−1.

**Reset values**
- All `alive` bits set; `aliensLeft` = ROWS×COLS.
- `xGrid` = X_START, `yGrid` = Y_START, direction = right, move counter = 0.
- `killingAlien`, `gameWon`, `gameLost` = 0.

**Hit detection.** Performed on each enable tick, using the pre-move `xGrid`/`yGrid`.
- relX = xLaser − xGrid; relY = yLaser − yGrid.
- Hit requires all of the following:
  - xLaser ≥ xGrid and yLaser ≥ yGrid
  - relX < COLS×PITCH_X and relY < ROWS×PITCH_Y
  - relX mod PITCH_X < ALIEN_W and relY mod PITCH_Y < ALIEN_H
  - the addressed `alive` bit is set
- col = relX / PITCH_X and row = relY / PITCH_Y, implemented as shifts and masks only.
- On a hit: clear the addressed bit, decrement `aliensLeft`, set `killingAlien` to 1.
- With no hit, `killingAlien` is 0.
- If `killingAlien` is already 1, no hit is evaluated on that tick. This prevents a double kill before the laser block reacts.

**Movement.** The move counter advances on every enable tick. A move occurs on each tick where the counter wraps.
- Moving right: if xGrid + STEP_X + (COLS−1)×PITCH_X + ALIEN_W ≤ SCREEN_WIDTH, then xGrid += STEP_X. Otherwise it is a reversal move.
- Moving left: if xGrid ≥ STEP_X, then xGrid −= STEP_X. Otherwise it is a reversal move.
- Reversal move: yGrid += STEP_Y, direction flips, xGrid is unchanged.
- Edge checks use the full formation extent, including dead columns.

**End of game**
- `gameWon` is set when `aliensLeft` reaches 0.
- `gameLost` is set when yGrid + (ROWS−1)×PITCH_Y + ALIEN_H ≥ INVASION_Y after a reversal move.
- Once either flag is set:
  - movement, hit detection and the move counter freeze until reset;
  - `killingAlien` is forced to 0 on the next tick.

**Colour**
- `colorAlien` = ALIEN when (hPos, vPos) passes the same box test against a set `alive` bit, using the registered grid position.
- Otherwise `colorAlien` = BACKGROUND.

## Timing
- Hit latency: `killingAlien` rises in the cycle after the enable tick that detected the hit. It stays high for exactly one enable period, so the laser block samples it on its next enable.
- Hit and move on the same tick: the hit is resolved against the old position, and both updates commit together.
- The kill that brings `aliensLeft` to 0 sets `gameWon` on the same tick.
- The dead-laser parking point (639, 479) never produces a hit; the `gameLost` freeze keeps the formation above it.
- `reset` mid-game restores all reset values in the next cycle, regardless of `enable`.
- `colorAlien` is purely combinational from the pixel inputs and registered state.

## Configuration
- `ALIEN_SPEEDUP_EN` defined:
  - effective move period = MOVE_PERIOD/2 when `aliensLeft` ≤ ROWS×COLS/2;
  - effective move period = MOVE_PERIOD/4 when `aliensLeft` ≤ ROWS×COLS/4;
  - the move counter is compared against the effective period, and a counter already at or beyond it wraps on the next tick.
- `ALIEN_SPEEDUP_EN` undefined: the period is always MOVE_PERIOD.

## Test plan
- Reset, then laser (84,50) with one enable tick → alive bit 0 cleared, `aliensLeft` 32→31, `killingAlien` = 1 for one enable period, then 0.
- Laser (110,50) in the inter-alien gap (relX mod 64 = 46) → no kill; `aliensLeft` stays 32.
- Laser held at (84,50) for 3 ticks after the first hit → exactly one kill; on the second tick `killingAlien` stays 1 with no re-evaluation.
- Idle laser (639,479) from reset:
  - `xGrid` steps 64, 68, … up to 152 on ticks 8 through 176;
  - tick 184 → `yGrid` = 56, `xGrid` = 152, direction = left.
- Hit all 32 aliens in sequence → `gameWon` = 1 on the last kill; `xGrid`/`yGrid` frozen for 100 further ticks.
- Assert `reset` after 5 kills → `aliensLeft` = 32, `xGrid` = 64, `yGrid` = 40, all flags 0.
- With `ALIEN_SPEEDUP_EN` defined, after 16 kills → moves occur every 4 enable ticks.
